// File: rtl/regu_intl_mc.sv
// regu_intl_mc -- multi-channel regulation interlock.
// Each channel tracks |set point - measured| in signed fixed point. After a
// set-point change or enable it waits a shared settle delay, then monitors.
// It trips after a programmable number of consecutive out-of-band samples.
// Trip flags are sticky per channel and are OR-ed into o_regu_any.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_clr             clears all sticky flags (level)
//   i_regu_en/i_mask  per-channel enable / force-to-IDLE mask
//   i_set_point       per-channel signed set point, ch k at [k*DW +: DW]
//   i_data            per-channel signed measured value, same packing
//   i_diff            per-channel unsigned tolerance, same packing
//   i_delay           settle delay in cycles (shared)
//   i_debounce        consecutive exceed samples to trip, 0 acts as 1 (shared)
//   o_regu_flag       sticky trip flag per channel
//   o_regu_any        OR of o_regu_flag
//   o_state           per-channel FSM state, ch k at [2k +: 2]
//   o_err_abs         registered |sp - data| per channel, saturated to DW bits
module regu_intl_mc #(
   parameter int N_CH = 4,
   parameter int DW   = 32,
   parameter int CW   = 32,
   parameter int DBW  = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_clr,
   input  logic [N_CH-1:0]      i_regu_en,
   input  logic [N_CH-1:0]      i_mask,
   input  logic [N_CH*DW-1:0]   i_set_point,
   input  logic [N_CH*DW-1:0]   i_data,
   input  logic [N_CH*DW-1:0]   i_diff,
   input  logic [CW-1:0]        i_delay,
   input  logic [DBW-1:0]       i_debounce,
   output logic [N_CH-1:0]      o_regu_flag,
   output logic                 o_regu_any,
   output logic [2*N_CH-1:0]    o_state,
   output logic [N_CH*DW-1:0]   o_err_abs
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_MON   = 2'd2,
      S_TRIP  = 2'd3
   } state_t;

   // A debounce of 0 behaves like 1: a single out-of-band sample trips.
   logic [DBW-1:0] w_deb_lim;
   assign w_deb_lim = (i_debounce == '0) ? DBW'(1) : i_debounce;

   assign o_regu_any = |o_regu_flag;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [DW-1:0]  w_sp, w_data, w_tol;
      logic [DW:0]    w_sub, w_mag;
      logic [DW-1:0]  r_sp_buf, r_err_abs;
      logic           r_en_d, r_exceed, r_flag;
      state_t         r_state, w_state_nxt;
      logic [CW-1:0]  r_delay_cnt, w_delay_nxt;
      logic [DBW-1:0] r_deb_cnt, w_deb_nxt;
      logic [DBW:0]   w_deb_inc;
      logic           w_sp_chg, w_en_rise, w_off, w_trip;

      assign w_sp   = i_set_point[k*DW +: DW];
      assign w_data = i_data[k*DW +: DW];
      assign w_tol  = i_diff[k*DW +: DW];

      // One extra bit keeps the full signed difference of two DW-bit values.
      assign w_sub = {w_sp[DW-1], w_sp} - {w_data[DW-1], w_data};
      assign w_mag = w_sub[DW] ? -w_sub : w_sub;

      assign w_sp_chg  = (r_sp_buf != w_sp);
      assign w_en_rise = i_regu_en[k] & ~r_en_d;
      assign w_off     = ~i_regu_en[k] | i_mask[k];
      // Widened so the +1 cannot wrap when the counter is saturated.
      assign w_deb_inc = (DBW+1)'(r_deb_cnt) + (DBW+1)'(1);

      // Input capture and the two-stage compare pipeline.
      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_sp_buf  <= '0;
            r_en_d    <= 1'b0;
            r_err_abs <= '0;
            r_exceed  <= 1'b0;
         end else begin
            r_sp_buf  <= w_sp;
            r_en_d    <= i_regu_en[k];
            r_err_abs <= w_mag[DW] ? '1 : w_mag[DW-1:0];
            r_exceed  <= (r_err_abs > w_tol);
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_delay_nxt = r_delay_cnt;
         w_deb_nxt   = r_deb_cnt;
         w_trip      = 1'b0;
         if (w_off) begin
            // Disable/mask beats everything, including a pending trip.
            w_state_nxt = S_IDLE;
            w_delay_nxt = '0;
            w_deb_nxt   = '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  w_delay_nxt = '0;
                  w_deb_nxt   = '0;
                  if (~r_flag & (w_sp_chg | w_en_rise))
                     w_state_nxt = S_DELAY;
               end
               S_DELAY: begin
                  if (w_sp_chg) begin
                     w_delay_nxt = '0;
                  end else if (r_delay_cnt >= i_delay) begin
                     w_state_nxt = S_MON;
                     w_deb_nxt   = '0;
                  end else if (r_delay_cnt != '1) begin
                     w_delay_nxt = r_delay_cnt + CW'(1);
                  end
               end
               S_MON: begin
                  if (r_exceed && (w_deb_inc >= (DBW+1)'(w_deb_lim))) begin
                     w_state_nxt = S_TRIP;
                     w_trip      = 1'b1;
                  end else if (w_sp_chg) begin
                     w_state_nxt = S_DELAY;
                     w_delay_nxt = '0;
                     w_deb_nxt   = '0;
                  end else if (r_exceed) begin
                     if (r_deb_cnt != '1)
                        w_deb_nxt = r_deb_cnt + DBW'(1);
                  end else begin
                     w_deb_nxt = '0;
                  end
               end
               S_TRIP: begin
                  if (i_clr)
                     w_state_nxt = S_IDLE;
               end
               default: w_state_nxt = S_IDLE;
            endcase
         end
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            r_state     <= S_IDLE;
            r_delay_cnt <= '0;
            r_deb_cnt   <= '0;
            r_flag      <= 1'b0;
         end else begin
            r_state     <= w_state_nxt;
            r_delay_cnt <= w_delay_nxt;
            r_deb_cnt   <= w_deb_nxt;
            // A trip on the same edge as i_clr wins, so the flag is never lost.
            r_flag      <= w_trip ? 1'b1 : (i_clr ? 1'b0 : r_flag);
         end
      end

      assign o_regu_flag[k]          = r_flag;
      assign o_state[2*k +: 2]       = r_state;
      assign o_err_abs[k*DW +: DW]   = r_err_abs;
   end

endmodule
